// File: rtl/mips_pkg.sv
// mips_pkg: opcodes, functs, ALU encodings and FSM states shared by the multicycle core
package mips_pkg;
  localparam logic [5:0] OP_R = 6'h00, OP_LW = 6'h23, OP_SW = 6'h2B, OP_BEQ = 6'h04, OP_ADDI = 6'h08, OP_J = 6'h02;
  localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24, FN_OR = 6'h25, FN_SLT = 6'h2A;
  localparam logic [2:0] ALU_ADD = 3'b010, ALU_SUB = 3'b110, ALU_AND = 3'b000, ALU_OR = 3'b001, ALU_SLT = 3'b111;
  localparam int unsigned DEF_RESET_PC = 0;
  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_ALUWB, S_MEMADR, S_MEMREAD,
    S_MEMWB, S_MEMWRITE, S_BRANCH, S_ADDIEXEC, S_ADDIWB, S_JUMP, S_TRAP
  } state_t;
  typedef enum logic [1:0] {SRCB_B, SRCB_4, SRCB_IMM, SRCB_IMM4} srcb_t;
  typedef enum logic [1:0] {PC_ALU, PC_ALUOUT, PC_JUMP} pcsrc_t;
endpackage

// File: rtl/mips_mc_controller.sv
// mips_mc_controller: multicycle FSM sequencing fetch, decode, execute, memory and writeback
module mips_mc_controller
  import mips_pkg::*;
#(
  parameter int ALUControl_WIDTH = 3
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [5:0]                  op,
  input  logic [5:0]                  funct,
  input  logic                        zero,
  input  logic                        mem_ready,
  output logic                        mem_req,
  output logic                        mem_we,
  output logic                        i_or_d,
  output logic                        ir_we,
  output logic                        pc_we,
  output logic                        ab_we,
  output logic                        alu_out_we,
  output logic                        mdr_we,
  output logic                        reg_we,
  output logic                        reg_dst,
  output logic                        mem_to_reg,
  output logic                        src_a,
  output srcb_t                       src_b,
  output pcsrc_t                      pc_src,
  output logic [ALUControl_WIDTH-1:0] alu_ctrl,
  output logic                        retire,
  output logic                        trap
);
  state_t state, next;
  logic r_ok;
  logic [2:0] fn_ctrl;
  always_ff @(posedge CLK or negedge RST)
    if (!RST) state <= S_IDLE;
    else state <= next;
  always_comb begin
    r_ok = funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
    fn_ctrl = funct == FN_SUB ? ALU_SUB : funct == FN_AND ? ALU_AND :
              funct == FN_OR ? ALU_OR : funct == FN_SLT ? ALU_SLT : ALU_ADD;
  end
  always_comb begin
    next = state;
    {mem_req, mem_we, i_or_d, ir_we, pc_we, ab_we, alu_out_we, mdr_we} = '0;
    {reg_we, reg_dst, mem_to_reg, src_a, retire, trap} = '0;
    src_b = SRCB_B;
    pc_src = PC_ALU;
    alu_ctrl = ALUControl_WIDTH'(ALU_ADD);
    case (state)
      S_IDLE: next = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        src_b = SRCB_4;
        ir_we = mem_ready;
        pc_we = mem_ready;
        next = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ab_we = 1'b1;
        alu_out_we = 1'b1;
        src_b = SRCB_IMM4;
        next = (op == OP_R && r_ok) ? S_EXECUTE : (op == OP_LW || op == OP_SW) ? S_MEMADR :
               op == OP_BEQ ? S_BRANCH : op == OP_ADDI ? S_ADDIEXEC : op == OP_J ? S_JUMP : S_TRAP;
      end
      S_EXECUTE: begin
        src_a = 1'b1;
        alu_ctrl = ALUControl_WIDTH'(fn_ctrl);
        alu_out_we = 1'b1;
        next = S_ALUWB;
      end
      S_ALUWB: begin
        reg_we = 1'b1;
        reg_dst = 1'b1;
        retire = 1'b1;
        next = S_FETCH;
      end
      S_MEMADR: begin
        src_a = 1'b1;
        src_b = SRCB_IMM;
        alu_out_we = 1'b1;
        next = op == OP_LW ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        i_or_d = 1'b1;
        mdr_we = mem_ready;
        next = mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        reg_we = 1'b1;
        mem_to_reg = 1'b1;
        retire = 1'b1;
        next = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req = 1'b1;
        mem_we = 1'b1;
        i_or_d = 1'b1;
        retire = mem_ready;
        next = mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_BRANCH: begin
        src_a = 1'b1;
        alu_ctrl = ALUControl_WIDTH'(ALU_SUB);
        pc_we = zero;
        pc_src = PC_ALUOUT;
        retire = 1'b1;
        next = S_FETCH;
      end
      S_ADDIEXEC: begin
        src_a = 1'b1;
        src_b = SRCB_IMM;
        alu_out_we = 1'b1;
        next = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_we = 1'b1;
        retire = 1'b1;
        next = S_FETCH;
      end
      S_JUMP: begin
        pc_we = 1'b1;
        pc_src = PC_JUMP;
        retire = 1'b1;
        next = S_FETCH;
      end
      S_TRAP: trap = 1'b1;
      default: next = S_IDLE;
    endcase
  end
endmodule

// File: rtl/mips_multicycle_core.sv
// mips_multicycle_core: multicycle MIPS datapath sharing one handshaked instruction/data memory port
module mips_multicycle_core
  import mips_pkg::*;
#(
  parameter int                   MIPS_SIZE        = 32,
  parameter int                   ALUControl_WIDTH = 3,
  parameter logic [MIPS_SIZE-1:0] RESET_PC         = MIPS_SIZE'(DEF_RESET_PC)
) (
  input  logic                 CLK,
  input  logic                 RST,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [MIPS_SIZE-1:0] mem_addr,
  output logic [MIPS_SIZE-1:0] mem_wdata,
  input  logic [MIPS_SIZE-1:0] mem_rdata,
  input  logic                 mem_ready,
  output logic                 retire,
  output logic                 trap,
  output logic [MIPS_SIZE-1:0] pc_out
);
  logic [MIPS_SIZE-1:0] pc, ir, a, b, alu_out, mdr, sa, sb, alu_res, sext, pc_next, wd;
  logic [31:0][MIPS_SIZE-1:0] rf;
  logic [4:0] wa;
  logic [ALUControl_WIDTH-1:0] alu_ctrl;
  logic i_or_d, ir_we, pc_we, ab_we, alu_out_we, mdr_we, reg_we, reg_dst, mem_to_reg, src_a, zero;
  srcb_t src_b;
  pcsrc_t pc_src;
  mips_mc_controller #(.ALUControl_WIDTH(ALUControl_WIDTH)) u_ctrl (
    .CLK(CLK), .RST(RST), .op(ir[31:26]), .funct(ir[5:0]), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .i_or_d(i_or_d), .ir_we(ir_we), .pc_we(pc_we),
    .ab_we(ab_we), .alu_out_we(alu_out_we), .mdr_we(mdr_we), .reg_we(reg_we), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .src_a(src_a), .src_b(src_b), .pc_src(pc_src), .alu_ctrl(alu_ctrl),
    .retire(retire), .trap(trap)
  );
  always_comb begin
    sext = {{(MIPS_SIZE-16){ir[15]}}, ir[15:0]};
    sa = src_a ? a : pc;
    sb = src_b == SRCB_B ? b : src_b == SRCB_4 ? MIPS_SIZE'(4) :
         src_b == SRCB_IMM ? sext : {sext[MIPS_SIZE-3:0], 2'b00};
    alu_res = alu_ctrl == ALUControl_WIDTH'(ALU_SUB) ? sa - sb :
              alu_ctrl == ALUControl_WIDTH'(ALU_AND) ? sa & sb :
              alu_ctrl == ALUControl_WIDTH'(ALU_OR) ? sa | sb :
              alu_ctrl == ALUControl_WIDTH'(ALU_SLT) ? {{(MIPS_SIZE-1){1'b0}}, $signed(sa) < $signed(sb)} :
              sa + sb;
    zero = alu_res == '0;
    pc_next = pc_src == PC_ALUOUT ? alu_out : pc_src == PC_JUMP ? {pc[MIPS_SIZE-1:28], ir[25:0], 2'b00} : alu_res;
    wa = reg_dst ? ir[15:11] : ir[20:16];
    wd = mem_to_reg ? mdr : alu_out;
    mem_addr = mem_req ? (i_or_d ? alu_out : pc) : '0;
    mem_wdata = mem_we ? b : '0;
    pc_out = pc;
  end
  // $0 is never written, so it keeps its reset value of zero
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      pc <= RESET_PC;
      {ir, a, b, alu_out, mdr} <= '0;
      rf <= '0;
    end else begin
      if (pc_we) pc <= pc_next;
      if (ir_we) ir <= mem_rdata;
      if (ab_we) {a, b} <= {rf[ir[25:21]], rf[ir[20:16]]};
      if (alu_out_we) alu_out <= alu_res;
      if (mdr_we) mdr <= mem_rdata;
      if (reg_we && wa != 5'd0) rf[wa] <= wd;
    end
endmodule

// File: tb/tb_mips_multicycle_core.sv
// tb_mips_multicycle_core: random and directed programs checked against an instruction-level model
module tb_mips_multicycle_core;
  typedef struct {logic [31:0] addr; logic we; logic [31:0] wdata;} acc_t;
  logic CLK = 1'b0, RST = 1'b0, mem_ready = 1'b0;
  logic mem_req, mem_we, retire, trap;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_out;
  logic [31:0] mem [256];
  logic [31:0] img [256];
  acc_t exp_acc[$];
  int exp_base[$];
  int rc[$];
  int exp_ret, total, bad;
  bit exp_trap;
  assign mem_rdata = mem[mem_addr[9:2]];
  always #5 CLK = ~CLK;
  mips_multicycle_core dut (
    .CLK(CLK), .RST(RST), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .retire(retire), .trap(trap), .pc_out(pc_out)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] r_ins(input int rs, input int rt, input int rd, input logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction
  function automatic logic [31:0] i_ins(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction
  task automatic iss(input int max_ins);
    logic [31:0] m [256];
    logic [31:0] r [32];
    logic [31:0] pc, ir, sx, ea, v;
    int rs, rt, rd;
    bit ill;
    m = img;
    r = '{default: '0};
    pc = 32'h0;
    exp_acc.delete();
    exp_base.delete();
    exp_ret = 0;
    exp_trap = 0;
    for (int n = 0; n < max_ins; n++) begin
      exp_acc.push_back(acc_t'{pc, 1'b0, 32'h0});
      ir = m[pc[9:2]];
      pc = pc + 4;
      sx = {{16{ir[15]}}, ir[15:0]};
      rs = int'(ir[25:21]);
      rt = int'(ir[20:16]);
      rd = int'(ir[15:11]);
      ill = 0;
      v = 0;
      case (ir[31:26])
        6'h00: begin
          case (ir[5:0])
            6'h20: v = r[rs] + r[rt];
            6'h22: v = r[rs] - r[rt];
            6'h24: v = r[rs] & r[rt];
            6'h25: v = r[rs] | r[rt];
            6'h2A: v = ($signed(r[rs]) < $signed(r[rt])) ? 32'd1 : 32'd0;
            default: ill = 1;
          endcase
          if (!ill && rd != 0) r[rd] = v;
          exp_base.push_back(4);
        end
        6'h23: begin
          ea = r[rs] + sx;
          exp_acc.push_back(acc_t'{ea, 1'b0, 32'h0});
          if (rt != 0) r[rt] = m[ea[9:2]];
          exp_base.push_back(5);
        end
        6'h2B: begin
          ea = r[rs] + sx;
          exp_acc.push_back(acc_t'{ea, 1'b1, r[rt]});
          m[ea[9:2]] = r[rt];
          exp_base.push_back(4);
        end
        6'h04: begin
          if (r[rs] == r[rt]) pc = pc + (sx << 2);
          exp_base.push_back(3);
        end
        6'h08: begin
          if (rt != 0) r[rt] = r[rs] + sx;
          exp_base.push_back(4);
        end
        6'h02: begin
          pc = {pc[31:28], ir[25:0], 2'b00};
          exp_base.push_back(3);
        end
        default: ill = 1;
      endcase
      if (ill) begin
        exp_trap = 1;
        break;
      end
      exp_ret++;
    end
  endtask
  // mode 0: random wait states; mode 1: delay reads of dly_addr by dly cycles; mode 2: stall writes then reset
  task automatic run_prog(input string nm, input int max_ins, input int mode, input int dly, input logic [31:0] dly_addr);
    int cyc = 0, wt = 0, wc = 0, steps = 0, ret = 0, ai = 0;
    bit pp = 0, done = 0;
    logic [31:0] pa = 0, pd = 0;
    logic pw = 0;
    iss(max_ins);
    for (int i = 0; i < 256; i++) mem[i] = img[i];
    rc.delete();
    mem_ready = 1'b0;
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    #1;
    chk({nm, ":rst_req"}, mem_req, 0);
    chk({nm, ":rst_pc"}, pc_out, 0);
    chk({nm, ":rst_trap"}, trap, 0);
    chk({nm, ":rst_retire"}, retire, 0);
    RST = 1'b1;
    #1;
    chk({nm, ":idle_req"}, mem_req, 0);
    while (!done) begin
      @(negedge CLK);
      mem_ready = mode == 0 ? ($urandom_range(0, 99) < 65) :
                  mode == 1 ? !(mem_req && !mem_we && mem_addr == dly_addr && wc < dly) : !(mem_req && mem_we);
      #1;
      cyc++;
      steps++;
      if (steps == 1) begin
        chk({nm, ":first_req"}, mem_req, 1);
        chk({nm, ":first_addr"}, mem_addr, 0);
      end
      if (pp) begin
        chk({nm, ":hold_req"}, mem_req, 1);
        chk({nm, ":hold_addr"}, mem_addr, pa);
        chk({nm, ":hold_we"}, mem_we, pw);
        chk({nm, ":hold_wdata"}, mem_wdata, pd);
      end
      pp = 0;
      if (mem_req && mem_ready) begin
        if (ai < exp_acc.size()) begin
          chk({nm, ":acc_addr"}, mem_addr, exp_acc[ai].addr);
          chk({nm, ":acc_we"}, mem_we, exp_acc[ai].we);
          if (exp_acc[ai].we) chk({nm, ":acc_wdata"}, mem_wdata, exp_acc[ai].wdata);
        end
        ai++;
        wc = 0;
        if (mem_we) mem[mem_addr[9:2]] = mem_wdata;
      end else if (mem_req) begin
        wt++;
        wc++;
        pp = 1;
        pa = mem_addr;
        pw = mem_we;
        pd = mem_wdata;
      end
      if (retire) begin
        if (ret < exp_base.size()) chk({nm, ":cycles"}, cyc, exp_base[ret] + wt);
        ret++;
        rc.push_back(cyc);
        cyc = 0;
        wt = 0;
      end
      if (mode == 2 && mem_req && mem_we && wc == 3) begin
        #2;
        RST = 1'b0;
        #1;
        chk({nm, ":abort_req"}, mem_req, 0);
        chk({nm, ":abort_we"}, mem_we, 0);
        chk({nm, ":abort_pc"}, pc_out, 0);
        return;
      end
      done = trap || (!exp_trap && ret == exp_ret) || steps >= 5000;
    end
    chk({nm, ":trap"}, trap, exp_trap);
    chk({nm, ":retires"}, ret, exp_ret);
    chk({nm, ":accesses"}, ai, exp_acc.size());
    if (exp_trap) begin
      repeat (10) begin
        @(negedge CLK);
        mem_ready = $urandom_range(0, 1);
        #1;
        chk({nm, ":trap_req"}, mem_req, 0);
        chk({nm, ":trap_retire"}, retire, 0);
        chk({nm, ":trap_sticky"}, trap, 1);
      end
      #2;
      RST = 1'b0;
      #1;
      chk({nm, ":trap_clear"}, trap, 0);
      chk({nm, ":trap_rst_req"}, mem_req, 0);
      chk({nm, ":trap_rst_pc"}, pc_out, 0);
    end
  endtask
  task automatic gen_random();
    int lim, t;
    logic [5:0] fn;
    for (int i = 0; i < 256; i++) img[i] = $urandom;
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: begin
          case ($urandom_range(0, 4))
            0: fn = 6'h20;
            1: fn = 6'h22;
            2: fn = 6'h24;
            3: fn = 6'h25;
            default: fn = 6'h2A;
          endcase
          img[k] = r_ins($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), fn);
        end
        3: img[k] = i_ins(6'h23, 0, $urandom_range(0, 7), 16'(32'h200 + 4 * $urandom_range(0, 63)));
        4: img[k] = i_ins(6'h2B, 0, $urandom_range(0, 7), 16'(32'h200 + 4 * $urandom_range(0, 63)));
        5, 6: img[k] = i_ins(6'h08, $urandom_range(0, 7), $urandom_range(0, 7), 16'($urandom));
        7, 8: begin
          lim = 39 - k > 3 ? 3 : 39 - k;
          t = $urandom_range(0, 7);
          img[k] = i_ins(6'h04, t, $urandom_range(0, 1) ? t : $urandom_range(0, 7), 16'($urandom_range(0, lim)));
        end
        default: begin
          lim = k + 4 > 40 ? 40 : k + 4;
          img[k] = {6'h02, 26'($urandom_range(k + 1, lim))};
        end
      endcase
    end
    for (int i = 1; i < 32; i++) img[39 + i] = i_ins(6'h2B, 0, i, 16'(32'h300 + 4 * i));
    img[71] = $urandom_range(0, 1) ? 32'hFC000000 : 32'h0000003F;
  endtask
  task automatic clear_img();
    for (int i = 0; i < 256; i++) img[i] = 32'hFC000000;
  endtask
  initial begin
    total = 0;
    bad = 0;
    clear_img();
    img[0] = i_ins(6'h08, 0, 2, 16'd5);
    img[1] = i_ins(6'h2B, 0, 2, 16'd12);
    run_prog("addi_sw", 100, 1, 0, 32'h0);
    chk("addi_cycles", rc.size() > 0 ? rc[0] : 0, 4);
    clear_img();
    img[0] = i_ins(6'h23, 0, 3, 16'd8);
    img[1] = i_ins(6'h2B, 0, 3, 16'h20);
    img[2] = 32'hDEADBEEF;
    run_prog("lw_wait", 100, 1, 3, 32'h8);
    chk("lw_cycles", rc.size() > 0 ? rc[0] : 0, 8);
    clear_img();
    img[0] = i_ins(6'h08, 0, 1, 16'd7);
    img[1] = i_ins(6'h08, 0, 4, 16'd3);
    img[2] = i_ins(6'h08, 0, 5, 16'd1);
    img[3] = i_ins(6'h08, 0, 6, 16'd2);
    img[4] = i_ins(6'h04, 1, 1, 16'hFFFF);
    run_prog("beq_taken", 7, 0, 0, 32'h0);
    img[4] = i_ins(6'h04, 1, 4, 16'hFFFF);
    run_prog("beq_not", 100, 0, 0, 32'h0);
    clear_img();
    img[0] = {6'h02, 26'h40};
    img[64] = i_ins(6'h08, 0, 2, 16'd9);
    img[65] = r_ins(2, 2, 0, 6'h20);
    img[66] = i_ins(6'h2B, 0, 0, 16'h20);
    img[67] = r_ins(2, 2, 7, 6'h20);
    img[68] = i_ins(6'h2B, 0, 7, 16'h24);
    run_prog("jump_r0", 100, 0, 0, 32'h0);
    clear_img();
    img[0] = i_ins(6'h08, 0, 2, 16'd5);
    img[1] = i_ins(6'h2B, 0, 2, 16'h40);
    run_prog("abort_sw", 100, 2, 0, 32'h0);
    for (int n = 0; n < 6; n++) begin
      gen_random();
      run_prog($sformatf("rand%0d", n), 200, 0, 0, 32'h0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mips_multicycle_core.md
# mips_multicycle_core

Multi-cycle, parametrised MIPS core that replaces the single-cycle top with one FSM-sequenced datapath and one shared instruction/data memory port. The port uses a request/ready handshake, so the core tolerates any number of memory wait states. The core sits between the testbench/SoC memory model and the existing register-file/ALU conventions. It adds two behaviours: a retire pulse per completed instruction and a trap on undefined opcodes.

## Interface
- MIPS_SIZE, 32: datapath, register, PC and memory-word width.
- ALUControl_WIDTH, 3: ALU control encoding width.
- RESET_PC, 0: PC value loaded on reset.
- CLK  in  1  single clock; all state updates on rising edge.
- RST  in  1  asynchronous, active-low reset.
- mem_req  out  1  memory access request; held until accepted.
- mem_we  out  1  write strobe, qualified by mem_req.
- mem_addr  out  MIPS_SIZE  byte address, word-aligned.
- mem_wdata  out  MIPS_SIZE  store data.
- mem_rdata  in  MIPS_SIZE  read data, valid when mem_ready=1.
- mem_ready  in  1  access completes in the cycle where mem_req=1 and mem_ready=1.
- retire  out  1  one-cycle pulse on the last cycle of each completed instruction.
- trap  out  1  sticky flag: undefined opcode or funct fetched; core halted.
- pc_out  out  MIPS_SIZE  current architectural PC (debug).

## Operation
- Supported instructions: add, sub, and, or, slt (opcode 0); lw 0x23; sw 0x2B; beq 0x04; addi 0x08; j 0x02. Any other opcode, or an R-type funct outside the five listed, sends the core to TRAP.
- ALUControl encoding: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- Register file: 32 x MIPS_SIZE. Register $0 reads 0 and ignores writes. Registers are written in writeback states only.
- State machine, with the reset state IDLE:
  - IDLE → FETCH unconditionally.
  - FETCH: mem_req=1, mem_addr=PC.
    - Stay while mem_ready=0.
    - On mem_ready: IR←mem_rdata, PC←PC+4, go to DECODE.
  - DECODE: A←rs, B←rt, ALUOut←PC+(signext(imm)<<2).
    - Next state by opcode: R→EXECUTE, lw/sw→MEMADR, beq→BRANCH, addi→ADDIEXEC, j→JUMP, else→TRAP.
  - EXECUTE: ALUOut←A op B → ALUWB. ALUWB writes rd←ALUOut → FETCH.
  - MEMADR: ALUOut←A+signext(imm). Then lw→MEMREAD, sw→MEMWRITE.
  - MEMREAD: mem_req=1, mem_we=0, addr=ALUOut. Wait for mem_ready, capture MDR → MEMWB. MEMWB writes rt←MDR → FETCH.
  - MEMWRITE: mem_req=1, mem_we=1, addr=ALUOut, wdata=B. Wait for mem_ready → FETCH.
  - BRANCH: if A==B then PC←ALUOut → FETCH.
  - ADDIEXEC: ALUOut←A+signext(imm) → ADDIWB. ADDIWB writes rt←ALUOut → FETCH.
  - JUMP: PC←{PC[31:28], IR[25:0], 2'b00} → FETCH.
  - TRAP: trap=1, mem_req=0, no state change until reset.
- Arithmetic is MIPS_SIZE-bit modulo with no overflow exception. slt is a signed compare. The PC wraps modulo 2^MIPS_SIZE.

## Timing
- Reset values: state=IDLE, PC=RESET_PC, IR=0, A=B=ALUOut=MDR=0, all registers 0. All outputs are 0 except pc_out=RESET_PC.
- First mem_req rises in the second cycle after RST deasserts (IDLE then FETCH).
- Zero-wait-state cycle counts, with each memory state adding one cycle per mem_ready=0 cycle:
  - R-type: 4
  - lw: 5
  - sw: 4
  - beq: 3
  - addi: 4
  - j: 3
- Handshake rules:
  - mem_addr, mem_we and mem_wdata stay stable while mem_req=1 and mem_ready=0.
  - mem_ready is ignored when mem_req=0.
- retire is high in the final state of each instruction: ALUWB, MEMWB, MEMWRITE on its accepting cycle, BRANCH, ADDIWB, JUMP. It is never high in TRAP.
- A register write in a writeback cycle is visible to the next instruction's DECODE; no forwarding is needed.
- RST asserted mid-access drops mem_req asynchronously. A pending write is abandoned and the memory side must discard it.

## Structure
- Package mips_pkg holds the opcode and funct constants, the ALUControl encodings, the FSM state enum and RESET_PC default.
- Sub-module mips_mc_controller contains the FSM and control decode: opcode/funct/zero/mem_ready in, enables and muxes out.
- The datapath with registers, register file, ALU and muxes lives in mips_multicycle_core.

## Test plan
- Reset release, memory with 0 waits, word 0 = addi $2,$0,5:
  - mem_req rises in cycle 2 with mem_addr=0.
  - After 4 cycles, $2=5 and retire has pulsed once.
- lw $3,8($0) with mem[8]=0xDEADBEEF and mem_ready delayed 3 cycles in MEMREAD:
  - $3=0xDEADBEEF.
  - Instruction takes 8 cycles.
  - mem_addr is held at 8 throughout the wait.
- sw $2,12($0) after $2=5:
  - One write with addr=12, wdata=5, mem_we=1.
  - Then the next fetch is at PC+4.
- beq $1,$1,-1 at 0x10:
  - Next fetch address is 0x10.
  - With unequal operands, the next fetch is 0x14.
- j 0x40 from PC 0x0: next fetch is 0x100. add $0,$2,$2 leaves $0 reading 0.
- Opcode 0x3F fetched:
  - trap=1 and mem_req=0 stays that way indefinitely, with no further retire.
  - Asserting RST mid-wait clears trap, and fetch restarts at RESET_PC.
